urng_pair_packer: RTL
=====================

# urng_pair_packer

Consumer-side block for the Tausworthe uniform generator. It takes the free-running 32-bit uniform word stream and packs consecutive word pairs into one 48-bit/16-bit uniform pair (u0, u1). It buffers the pairs in a small FIFO and serves them to the AWGN Box-Muller datapath over a valid/ready handshake. Words that arrive while the buffer cannot accept a pair are discarded, so the generator never needs back-pressure.

## Interface
- DEPTH, 4, number of FIFO entries in pairs; power of two, ≥2.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Tin  input  32  uniform word from the Tausworthe generator.
- tin_valid  input  1  Tin holds a new word this cycle (normally tied high after generator reset).
- u0  output  48  head pair, high part; 0 while out_valid=0.
- u1  output  16  head pair, low part; 0 while out_valid=0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head pair this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy in pairs.
- drop_cnt  output  16  discarded-pair count (present only with URNG_DROP_CNT_EN).

## Operation
- Phase bit `ph` and a 32-bit holding register `hold`.
- When tin_valid=1 and ph=0: `hold`←Tin, ph←1.
- When tin_valid=1 and ph=1: form the pair A=`hold`, B=Tin; ph←0.
  - u0 = {A[31:0], B[31:16]}.
  - u1 = B[15:0].
- tin_valid=0: no state change in the packer.
- Push happens on the cycle a pair is formed, if level<DEPTH or a pop occurs in the same cycle.
- Otherwise the pair is dropped. With the macro, drop_cnt increments.
- Pop happens when out_valid=1 and out_ready=1. Head advances.
- out_ready while empty is ignored.
- Simultaneous push and pop: level unchanged, both pointers advance. This holds even at level=DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is a separate counter, 0..DEPTH.
- u0/u1 are read from the head entry and ANDed with out_valid. Stale storage is never visible.
- Reset (any cycle, including mid-pair or with a full FIFO):
  - ph=0; the held partial word is discarded.
  - Pointers 0, level=0, out_valid=0, u0=0, u1=0, drop_cnt=0.
  - Storage contents are not cleared.
  - Tin/tin_valid are ignored during the reset cycle.

## Timing
- Latency: the pair is pushed on the edge ending the cycle of its second word. out_valid=1 and u0/u1 are valid the next cycle.
- Sustained throughput: one pair per two tin_valid cycles in, one pair per cycle out.
- out_valid and level are registered. u0/u1 are combinational from the registered head pointer and storage.
- out_valid stays high and u0/u1 stay stable until popped; a push alone does not change them.
- A pop when level=1 with a simultaneous push causes the new pair to appear on the next cycle; out_valid stays 1.
- First pair after reset release with tin_valid tied high: out_valid rises 2 cycles after reset deasserts.

## Configuration
- URNG_DROP_CNT_EN defined:
  - drop_cnt port and a 16-bit counter are present.
  - The counter increments once per dropped pair and saturates at 0xFFFF.
  - Reset clears it to 0.
- Not defined: the drop_cnt port and counter are absent; dropped pairs are silently lost. All other behaviour is identical.

## Test plan
- Reset held 3 cycles with tin_valid=1 and random Tin -> out_valid=0, level=0, u0=0, u1=0, drop_cnt=0 throughout and on the first cycle after release.
- Tin=0x11112222 then 0x33334444 (tin_valid=1), out_ready=0 -> next cycle out_valid=1, u0=0x111122223333, u1=0x4444, level=1.
- DEPTH=4, out_ready=0, 10 consecutive words -> level=4 after word 8; pair from words 9–10 dropped; drop_cnt=1; head still pair 1.
- level=4, out_ready=1 on the cycle word 10 arrives -> pair accepted, level stays 4, drop_cnt=0, head becomes pair 2.
- Word 0xAAAAAAAA, 3 cycles tin_valid=0, word 0xBBBBBBBB -> exactly one pair: u0=0xAAAAAAAABBBB, u1=0xBBBB.
- Word 0xDEADBEEF, reset 1 cycle, then words 0x01234567 and 0x89ABCDEF -> single pair u0=0x0123456789AB, u1=0xCDEF; the 0xDEADBEEF word never appears.

Source files
------------

// File: rtl/urng_pair_packer_if.sv
// Uniform-pair stream bundle: 32-bit word input side and the 48/16-bit pair output side.
// drop_cnt is carried only when URNG_DROP_CNT_EN is defined.
interface urng_pair_packer_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   Tin;
  logic          tin_valid;
  logic [47:0]   u0;
  logic [15:0]   u1;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
`ifdef URNG_DROP_CNT_EN
  logic [15:0]   drop_cnt;

  modport slave (
    input  Tin, tin_valid, out_ready,
    output u0, u1, out_valid, level, drop_cnt
  );

  modport master (
    output Tin, tin_valid, out_ready,
    input  u0, u1, out_valid, level, drop_cnt
  );
`else
  modport slave (
    input  Tin, tin_valid, out_ready,
    output u0, u1, out_valid, level
  );

  modport master (
    output Tin, tin_valid, out_ready,
    input  u0, u1, out_valid, level
  );
`endif
endinterface

// File: rtl/urng_pair_packer.sv
// Packs word pairs from the Tausworthe stream into (u0,u1) pairs and buffers them in a
// DEPTH-entry FIFO; pairs that find no room are dropped. Optional: URNG_DROP_CNT_EN.
module urng_pair_packer #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  urng_pair_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic          r_ph;
  logic [31:0]   r_hold;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_out_valid;
  logic [63:0]   r_mem [DEPTH];

  logic          w_pair_valid;
  logic          w_pop;
  logic          w_push;
  logic [63:0]   w_pair;
  logic [63:0]   w_head;
  logic [LW-1:0] w_level_next;

  assign w_pair_valid = bus.tin_valid & r_ph;
  assign w_pop        = r_out_valid & bus.out_ready;
  // A full FIFO still accepts a pair when the head leaves in the same cycle.
  assign w_push       = w_pair_valid & ((r_level != FULL) | w_pop);
  assign w_pair       = {r_hold, bus.Tin};

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph        <= 1'b0;
      r_hold      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (bus.tin_valid) begin
        r_ph <= ~r_ph;
        if (!r_ph) r_hold <= bus.Tin;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level     <= w_level_next;
      r_out_valid <= (w_level_next != '0);
    end
  end

  // Storage is deliberately left out of reset; the output mask hides stale entries.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= w_pair;
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign bus.u0        = w_head[63:16] & {48{r_out_valid}};
  assign bus.u1        = w_head[15:0]  & {16{r_out_valid}};
  assign bus.out_valid = r_out_valid;
  assign bus.level     = r_level;

`ifdef URNG_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = w_pair_valid & ~w_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif
endmodule
